// File: rtl/freepdk45_sram_1w1r_param.sv
// freepdk45_sram_1w1r_param
// Behavioural model of a single-clock FreePDK45 1W1R synchronous SRAM.
// Port 0 writes with per-lane enables; port 1 reads with a latency of one
// or two clocks and flags completed reads on dout1_valid. Same-address
// read/write cycles follow RDW_MODE and are counted in a saturating counter.
// Accesses beyond RAM_DEPTH are ignored (reads return zero) and set a
// sticky error flag.
//
// Ports:
//   clk0          : clock for both ports, all state changes on posedge
//   rst_n         : asynchronous active-low reset (array contents kept)
//   csb0          : write select, active low
//   addr0         : write address
//   wmask0        : per-lane write enables, active high
//   din0          : write data
//   csb1          : read select, active low
//   addr1         : read address
//   dout1         : read data, holds its value between reads
//   dout1_valid   : one-cycle strobe marking new data on dout1
//   collision_cnt : saturating count of same-address read/write cycles
//   oob_err       : sticky out-of-range access flag
module freepdk45_sram_1w1r_param #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 9,
  parameter int RAM_DEPTH    = 512,
  parameter int WMASK_WIDTH  = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk0,
  input  logic                   rst_n,
  input  logic                   csb0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic [CNT_WIDTH-1:0]   collision_cnt,
  output logic                   oob_err
);

  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  // Reject configurations the model cannot represent.
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_lanes
    $fatal(1, "DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "RAM_DEPTH exceeds the address space");
  end

  // Replace the enabled lanes of old_word with the matching lanes of new_word.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0]  old_word,
    input logic [DATA_WIDTH-1:0]  new_word,
    input logic [WMASK_WIDTH-1:0] mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (mask[i]) begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
      end else begin
        merged[i*LANE_WIDTH +: LANE_WIDTH] = old_word[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  collision_s;
  logic                  oob_hit_s;
  logic [DATA_WIDTH-1:0] wr_old_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] rd_old_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  stage_valid_s;
  logic [DATA_WIDTH-1:0] stage_data_s;

  // A depth that fills the address space makes every address legal.
  if (RAM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_depth
    assign wr_in_range_s = 1'b1;
    assign rd_in_range_s = 1'b1;
  end else begin : g_part_depth
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = RAM_DEPTH[ADDR_WIDTH:0];
    assign wr_in_range_s = ({1'b0, addr0} < DEPTH_LIMIT);
    assign rd_in_range_s = ({1'b0, addr1} < DEPTH_LIMIT);
  end

  assign wr_en_s     = !csb0 && wr_in_range_s;
  assign rd_en_s     = !csb1;
  // wr_en_s already implies the shared address is in range.
  assign collision_s = wr_en_s && rd_en_s && (addr0 == addr1);
  assign oob_hit_s   = (!csb0 && !wr_in_range_s) || (!csb1 && !rd_in_range_s);

  // Fetch the current words at both addresses, zero when out of range.
  always_comb begin
    wr_old_s = {DATA_WIDTH{1'b0}};
    rd_old_s = {DATA_WIDTH{1'b0}};
    if (wr_in_range_s) begin
      wr_old_s = mem[addr0];
    end else begin
      wr_old_s = {DATA_WIDTH{1'b0}};
    end
    if (rd_in_range_s) begin
      rd_old_s = mem[addr1];
    end else begin
      rd_old_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign wr_word_s = lane_merge(wr_old_s, din0, wmask0);

  // Choose the read word; write-through forwards the merged write word.
  always_comb begin
    rd_word_s = rd_old_s;
    if (collision_s && (RDW_MODE == 1)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk0) begin
    if (wr_en_s) begin
      mem[addr0] <= wr_word_s;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  pipe_valid_r;
    logic [DATA_WIDTH-1:0] pipe_data_r;

    // Extra read stage; its valid bit is cleared by reset to drop in-flight reads.
    always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
        pipe_valid_r <= 1'b0;
        pipe_data_r  <= {DATA_WIDTH{1'b0}};
      end else begin
        pipe_valid_r <= rd_en_s;
        if (rd_en_s) begin
          pipe_data_r <= rd_word_s;
        end
      end
    end

    assign stage_valid_s = pipe_valid_r;
    assign stage_data_s  = pipe_data_r;
  end else begin : g_lat1
    assign stage_valid_s = rd_en_s;
    assign stage_data_s  = rd_word_s;
  end

  // Output register: dout1 only changes when a read completes.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      dout1       <= {DATA_WIDTH{1'b0}};
      dout1_valid <= 1'b0;
    end else begin
      dout1_valid <= stage_valid_s;
      if (stage_valid_s) begin
        dout1 <= stage_data_s;
      end
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      collision_cnt <= {CNT_WIDTH{1'b0}};
    end else if (collision_s && (collision_cnt != {CNT_WIDTH{1'b1}})) begin
      collision_cnt <= collision_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      oob_err <= 1'b0;
    end else if (oob_hit_s) begin
      oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freepdk45_sram_1w1r_param.sv
// Testbench for freepdk45_sram_1w1r_param. Two instances share stimulus:
//   u_a : RAM_DEPTH=300, READ_LATENCY=1, RDW_MODE=0, CNT_WIDTH=4
//   u_b : RAM_DEPTH=512, READ_LATENCY=2, RDW_MODE=1, CNT_WIDTH=16
// A behavioural model pushes expected read results with their due cycle;
// per-instance monitors pop and compare on every falling edge.
module tb_freepdk45_sram_1w1r_param;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        csb0;
  logic [8:0]  addr0;
  logic [7:0]  wmask0;
  logic [63:0] din0;
  logic        csb1;
  logic [8:0]  addr1;

  logic [63:0] dout_a, dout_b;
  logic        valid_a, valid_b;
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic        oob_a, oob_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [63:0] ma [300];
  logic [63:0] mb [512];
  logic [3:0]  m_cnt_a;
  logic [15:0] m_cnt_b;
  logic        m_oob_a, m_oob_b;

  freepdk45_sram_1w1r_param #(
    .RAM_DEPTH(300), .READ_LATENCY(1), .RDW_MODE(0), .CNT_WIDTH(4)
  ) u_a (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .wmask0(wmask0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_a),
    .dout1_valid(valid_a), .collision_cnt(cnt_a), .oob_err(oob_a)
  );

  freepdk45_sram_1w1r_param #(
    .RAM_DEPTH(512), .READ_LATENCY(2), .RDW_MODE(1), .CNT_WIDTH(16)
  ) u_b (
    .clk0(clk0), .rst_n(rst_n), .csb0(csb0), .addr0(addr0), .wmask0(wmask0),
    .din0(din0), .csb1(csb1), .addr1(addr1), .dout1(dout_b),
    .dout1_valid(valid_b), .collision_cnt(cnt_b), .oob_err(oob_b)
  );

  always #5 clk0 = ~clk0;

  // Cycle counter used to time expected strobes.
  always @(posedge clk0) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] mask);
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  // Drive one edge of stimulus at the falling edge and update the model.
  task automatic drive(input logic we, input logic [8:0] wa, input logic [7:0] wm,
                       input logic [63:0] wd, input logic re, input logic [8:0] ra);
    logic  wok, rok, coll;
    logic [63:0] rd;
    exp_t e;
    @(negedge clk0);
    csb0 = ~we; addr0 = wa; wmask0 = wm; din0 = wd; csb1 = ~re; addr1 = ra;
    // instance A: depth 300, read-old, latency 1
    wok  = we && (wa < 9'd300);
    rok  = re && (ra < 9'd300);
    coll = wok && re && (wa == ra);
    rd   = rok ? ma[ra] : 64'd0;
    if (re) begin e.data = rd; e.due = cyc + 1; qa.push_back(e); end
    if ((we && !wok) || (re && !rok)) m_oob_a = 1'b1;
    if (coll && m_cnt_a != 4'hF) m_cnt_a = m_cnt_a + 4'd1;
    if (wok) ma[wa] = merge(ma[wa], wd, wm);
    // instance B: full depth, write-through, latency 2
    coll = we && re && (wa == ra);
    rd   = re ? mb[ra] : 64'd0;
    if (coll) rd = merge(rd, wd, wm);
    if (re) begin e.data = rd; e.due = cyc + 2; qb.push_back(e); end
    if (coll && m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
    if (we) mb[wa] = merge(mb[wa], wd, wm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b0, 9'd0);
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_cnt_a"}, 64'(cnt_a), 64'(m_cnt_a));
    check_val({tag, "_cnt_b"}, 64'(cnt_b), 64'(m_cnt_b));
    check_val({tag, "_oob_a"}, 64'(oob_a), 64'(m_oob_a));
    check_val({tag, "_oob_b"}, 64'(oob_b), 64'(m_oob_b));
  endtask

  // Scoreboard for instance A: strobe timing and data.
  always @(negedge clk0) begin : mon_a
    logic exp_v;
    exp_t e;
    exp_v = (qa.size() > 0) && (qa[0].due == cyc);
    check_val("a_valid", 64'(valid_a), 64'(exp_v));
    if (exp_v) begin
      e = qa.pop_front();
      check_val("a_dout", dout_a, e.data);
    end
  end

  // Scoreboard for instance B: strobe timing and data.
  always @(negedge clk0) begin : mon_b
    logic exp_v;
    exp_t e;
    exp_v = (qb.size() > 0) && (qb[0].due == cyc);
    check_val("b_valid", 64'(valid_b), 64'(exp_v));
    if (exp_v) begin
      e = qb.pop_front();
      check_val("b_dout", dout_b, e.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    csb0 = 1'b1; addr0 = 9'd0; wmask0 = 8'h00; din0 = 64'd0;
    csb1 = 1'b1; addr1 = 9'd0;
    m_cnt_a = 4'd0; m_cnt_b = 16'd0; m_oob_a = 1'b0; m_oob_b = 1'b0;
    repeat (2) @(negedge clk0);
    check_val("rst_dout_a", dout_a, 64'd0);
    check_val("rst_dout_b", dout_b, 64'd0);
    check_status("rst");
    rst_n = 1'b1;

    // Byte-mask write: upper lanes keep ones, lower lanes cleared.
    drive(1'b1, 9'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 9'd0);
    drive(1'b1, 9'd5, 8'h0F, 64'h0, 1'b0, 9'd0);
    drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'd5);
    idle(3);

    // Preload and back-to-back reads.
    for (int i = 0; i < 4; i++) drive(1'b1, 9'(i), 8'hFF, 64'(16 + i), 1'b0, 9'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'(i));
    idle(3);

    // Read-during-write on address 7.
    drive(1'b1, 9'd7, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 9'd0);
    drive(1'b1, 9'd7, 8'h01, 64'h5555_5555_5555_5555, 1'b1, 9'd7);
    idle(1);
    check_status("rdw");
    drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'd7);
    idle(3);

    // Counter saturation: 20 collisions on address 8.
    for (int i = 0; i < 20; i++) drive(1'b1, 9'd8, 8'hFF, 64'(i * 3 + 1), 1'b1, 9'd8);
    idle(3);
    check_status("sat");

    // Out of range for A (depth 300), in range for B.
    drive(1'b1, 9'd310, 8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b0, 9'd0);
    drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'd310);
    drive(1'b1, 9'd310, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 9'd310);
    idle(10);
    check_status("oob");

    // Reset while a read of address 3 is in flight.
    drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'd3);
    @(posedge clk0);
    #2;
    rst_n = 1'b0;
    csb1 = 1'b1;
    qa.delete(); qb.delete();
    m_cnt_a = 4'd0; m_cnt_b = 16'd0; m_oob_a = 1'b0; m_oob_b = 1'b0;
    #1;
    check_val("mid_rst_dout_a", dout_a, 64'd0);
    check_val("mid_rst_dout_b", dout_b, 64'd0);
    check_val("mid_rst_valid_a", 64'(valid_a), 64'd0);
    check_val("mid_rst_valid_b", 64'(valid_b), 64'd0);
    check_status("mid_rst");
    @(negedge clk0);
    @(negedge clk0);
    rst_n = 1'b1;
    idle(4);
    drive(1'b0, 9'd0, 8'h00, 64'd0, 1'b1, 9'd3);
    idle(4);
    check_status("end");
    check_val("a_queue_empty", 64'(qa.size()), 64'd0);
    check_val("b_queue_empty", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
